// File: rtl/uart_buffered.sv
// Buffered UART: TX FIFO feeding a serializer, RX deserializer feeding an
// RX FIFO, with sticky parity / framing / overrun flags.

// Synchronous FIFO with first-word-fall-through head and N+1 bit pointers.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update; wraps naturally modulo 2*DEPTH.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end
endmodule

module uart_buffered #(
  parameter int FREQ_HZ    = 12000000,
  parameter int BAUDS      = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_i,
  output logic                 tx_o,
  input  logic                 rx_i,
  input  logic                 wr_i,
  input  logic [DATA_BITS-1:0] tx_data_i,
  input  logic                 rd_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 busy_o,
  output logic                 valid_o,
  output logic                 tx_idle_o,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  input  logic                 clr_err_i
);
  localparam int DIV = (FREQ_HZ + BAUDS / 2) / BAUDS;
  localparam int CW  = (DIV < 4) ? 2 : $clog2(DIV);
  localparam logic [CW-1:0] DIV_M1    = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1   = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [2:0]    LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic          ODD       = (PARITY == 1);

  if (DIV < 4) begin : g_bad_div
    $fatal(1, "uart_buffered: bit period below 4 clock cycles");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_bits
    $fatal(1, "uart_buffered: DATA_BITS must be 5..8");
  end

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

  // ---------------- FIFOs ----------------
  logic                 tx_pop, tx_full, tx_empty;
  logic [DATA_BITS-1:0] tx_head;
  logic                 rx_push, rx_full, rx_empty;

  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .reset_i(reset_i), .push_i(wr_i), .pop_i(tx_pop),
    .data_i(tx_data_i), .data_o(tx_head), .full_o(tx_full), .empty_o(tx_empty)
  );

  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;

  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .reset_i(reset_i), .push_i(rx_push), .pop_i(rd_i),
    .data_i(rx_shift_q), .data_o(rx_data_o), .full_o(rx_full), .empty_o(rx_empty)
  );

  // ---------------- transmitter ----------------
  tx_state_e            tx_state_q, tx_state_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [2:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_line_q, tx_line_d;

  // TX state register; reset forces the line idle immediately.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_line_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_line_q  <= tx_line_d;
    end
  end

  // TX next state: each bit level is held for DIV cycles, frames chain without gaps.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_line_d  = tx_line_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_line_d = 1'b1;
        tx_pop    = !tx_empty;
      end
      TX_START: begin
        if (tx_cnt_q == '0) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = DIV_M1;
          tx_bit_d   = '0;
          tx_line_d  = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_ONE;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d = DIV_M1;
          if (tx_bit_q == LAST_DATA) begin
            tx_bit_d = '0;
            if (PARITY != 0) begin
              tx_state_d = TX_PARITY;
              tx_line_d  = tx_par_q;
            end else begin
              tx_state_d = TX_STOP;
              tx_line_d  = 1'b1;
            end
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = tx_shift_q >> 1;
            tx_line_d  = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_ONE;
        end
      end
      TX_PARITY: begin
        if (tx_cnt_q == '0) begin
          tx_state_d = TX_STOP;
          tx_cnt_d   = DIV_M1;
          tx_bit_d   = '0;
          tx_line_d  = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_ONE;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == '0) begin
          if (tx_bit_q == LAST_STOP) begin
            if (!tx_empty) begin
              tx_pop = 1'b1;
            end else begin
              tx_state_d = TX_IDLE;
              tx_line_d  = 1'b1;
            end
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
            tx_cnt_d = DIV_M1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_ONE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    // Loading a new word always begins a start bit.
    if (tx_pop) begin
      tx_shift_d = tx_head;
      tx_par_d   = (^tx_head) ^ ODD;
      tx_state_d = TX_START;
      tx_cnt_d   = DIV_M1;
      tx_line_d  = 1'b0;
    end
  end

  // ---------------- receiver ----------------
  logic                 rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e            rx_state_q, rx_state_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [2:0]           rx_bit_q, rx_bit_d;
  logic                 rx_par_q, rx_par_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 frame_set, parity_set, overrun_set;
  logic                 parity_err_q, frame_err_q, overrun_q;

  // Two-flop synchronizer plus edge-history flop, preloaded with line idle.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // RX state register and sticky error flags.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_par_q     <= 1'b0;
      rx_perr_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_par_q     <= rx_par_d;
      rx_perr_q    <= rx_perr_d;
      parity_err_q <= parity_set  | (parity_err_q & ~clr_err_i);
      frame_err_q  <= frame_set   | (frame_err_q  & ~clr_err_i);
      overrun_q    <= overrun_set | (overrun_q    & ~clr_err_i);
    end
  end

  // RX next state: falling edge arms, then samples at mid-bit every DIV cycles.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_par_d   = rx_par_q;
    rx_perr_d  = rx_perr_q;
    rx_push    = 1'b0;
    frame_set  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = HALF_M1;
          rx_par_d   = 1'b0;
          rx_perr_d  = 1'b0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == '0) begin
          if (rx_sync_q) begin
            rx_state_d = RX_IDLE;          // glitch, not a start bit
          end else begin
            rx_state_d = RX_DATA;
            rx_cnt_d   = DIV_M1;
            rx_bit_d   = '0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_ONE;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
          rx_par_d   = rx_par_q ^ rx_sync_q;
          rx_cnt_d   = DIV_M1;
          if (rx_bit_q == LAST_DATA) begin
            rx_bit_d   = '0;
            rx_state_d = (PARITY != 0) ? RX_PARITY : RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_ONE;
        end
      end
      RX_PARITY: begin
        if (rx_cnt_q == '0) begin
          rx_perr_d  = rx_par_q ^ rx_sync_q ^ ODD;
          rx_state_d = RX_STOP;
          rx_cnt_d   = DIV_M1;
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_ONE;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == '0) begin
          // Only the first stop bit is checked; a low line must rise before re-arming.
          rx_state_d = RX_IDLE;
          if (rx_sync_q) rx_push   = 1'b1;
          else           frame_set = 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_ONE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  assign parity_set  = rx_push & rx_perr_q;
  assign overrun_set = rx_push & rx_full & ~rd_i;

  // ---------------- outputs ----------------
  assign tx_o         = tx_line_q;
  assign busy_o       = tx_full;
  assign valid_o      = !rx_empty;
  assign tx_idle_o    = tx_empty && (tx_state_q == TX_IDLE);
  assign parity_err_o = parity_err_q;
  assign frame_err_o  = frame_err_q;
  assign overrun_o    = overrun_q;
endmodule

// File: tb/tb_uart_buffered.sv
// Bench for uart_buffered: queue-based scoreboards for RX words and TX frames,
// directed stimulus for loopback, FIFO limits, errors, glitch and reset.
module tb_uart_buffered;
  localparam int DIV = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_i = 1'b0;

  // DUT A: even parity, 4-deep FIFOs, optional loopback.
  logic       tx_a, rx_a, wr_a = 1'b0, rd_a = 1'b0, clr_a = 1'b0;
  logic [7:0] txd_a = 8'h00, rxd_a;
  logic       busy_a, valid_a, idle_a, perr_a, ferr_a, ovr_a;
  logic       loop_en = 1'b0, rx_drv = 1'b1;
  assign rx_a = loop_en ? tx_a : rx_drv;

  uart_buffered #(.FREQ_HZ(12000000), .BAUDS(1000000), .DATA_BITS(8),
                  .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .reset_i(reset_i), .tx_o(tx_a), .rx_i(rx_a), .wr_i(wr_a),
    .tx_data_i(txd_a), .rd_i(rd_a), .rx_data_o(rxd_a), .busy_o(busy_a),
    .valid_o(valid_a), .tx_idle_o(idle_a), .parity_err_o(perr_a),
    .frame_err_o(ferr_a), .overrun_o(ovr_a), .clr_err_i(clr_a)
  );

  // DUT B: 8N1 for the raw waveform check.
  logic       tx_b, rx_b = 1'b1, wr_b = 1'b0, rd_b = 1'b0, clr_b = 1'b0;
  logic [7:0] txd_b = 8'h00, rxd_b;
  logic       busy_b, valid_b, idle_b, perr_b, ferr_b, ovr_b;

  uart_buffered #(.FREQ_HZ(12000000), .BAUDS(1000000), .DATA_BITS(8),
                  .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u_dut_n1 (
    .clk(clk), .reset_i(reset_i), .tx_o(tx_b), .rx_i(rx_b), .wr_i(wr_b),
    .tx_data_i(txd_b), .rd_i(rd_b), .rx_data_o(rxd_b), .busy_o(busy_b),
    .valid_o(valid_b), .tx_idle_o(idle_b), .parity_err_o(perr_b),
    .frame_err_o(ferr_b), .overrun_o(ovr_b), .clr_err_i(clr_b)
  );

  logic [7:0] rx_exp[$];
  logic [7:0] tx_exp[$];
  int  n_vec = 0, n_bad = 0, epoch = 0;
  bit  rd_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // RX monitor: pops and compares whenever the DUT presents a word.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      rd_a = 1'b0;
      if (rd_en && valid_a && reset_i) begin
        if (rx_exp.size() == 0) begin
          check("rx_word_expected", 32'(rx_exp.size()), 1);
        end else begin
          e = rx_exp.pop_front();
          check("rx_word", {24'h0, rxd_a}, {24'h0, e});
        end
        rd_a = 1'b1;
      end
    end
  end

  // TX monitor: decodes frames on DUT A's line and compares with queued words.
  initial begin
    bit prev;
    logic [7:0] w;
    logic s, p, st;
    int ep;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (reset_i && prev && !tx_a) begin
        ep = epoch;
        repeat (DIV/2 - 1) @(negedge clk);
        s = tx_a;
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          w[i] = tx_a;
        end
        repeat (DIV) @(negedge clk);
        p = tx_a;
        repeat (DIV) @(negedge clk);
        st = tx_a;
        if (ep == epoch && reset_i) begin
          check("tx_start_bit", {31'h0, s}, 0);
          if (tx_exp.size() == 0) begin
            check("tx_frame_expected", 32'(tx_exp.size()), 1);
          end else begin
            check("tx_word", {24'h0, w}, {24'h0, tx_exp.pop_front()});
          end
          check("tx_parity_bit", {31'h0, p}, {31'h0, ^w});
          check("tx_stop_bit", {31'h0, st}, 1);
        end
      end
      prev = tx_a;
    end
  end

  task automatic write_a(input logic [7:0] d, input bit loop);
    txd_a = d;
    wr_a  = 1'b1;
    tx_exp.push_back(d);
    if (loop) rx_exp.push_back(d);
    @(negedge clk);
    wr_a = 1'b0;
  endtask

  // Drives one even-parity 8-bit frame on rx_drv, optionally corrupted.
  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    rx_drv = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      repeat (DIV) @(negedge clk);
    end
    rx_drv = (^d) ^ bad_par;
    repeat (DIV) @(negedge clk);
    rx_drv = ~bad_stop;
    repeat (DIV) @(negedge clk);
    if (bad_stop) repeat (DIV) @(negedge clk);
    rx_drv = 1'b1;
    repeat (3*DIV) @(negedge clk);
  endtask

  task automatic pulse_clr();
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] a5_frame;
    int t;
    a5_frame = {1'b1, 8'hA5, 1'b0};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tx_o", {31'h0, tx_a}, 1);
    check("rst_busy", {31'h0, busy_a}, 0);
    check("rst_valid", {31'h0, valid_a}, 0);
    check("rst_tx_idle", {31'h0, idle_a}, 1);
    check("rst_errs", {29'h0, perr_a, ferr_a, ovr_a}, 0);
    check("rst_tx_b", {31'h0, tx_b}, 1);
    reset_i = 1'b1;
    @(negedge clk);

    // 8N1 waveform of 0xA5, each level held DIV cycles
    txd_b = 8'hA5;
    wr_b  = 1'b1;
    @(negedge clk);
    wr_b  = 1'b0;
    for (int k = 0; k < 10*DIV; k++) begin
      @(negedge clk);
      check("n1_tx_level", {31'h0, tx_b}, {31'h0, a5_frame[k/DIV]});
    end
    @(negedge clk);
    check("n1_tx_idle_after", {31'h0, idle_b}, 1);

    // Loopback with even parity
    loop_en = 1'b1;
    rd_en   = 1'b1;
    write_a(8'h00, 1'b1);
    write_a(8'hFF, 1'b1);
    write_a(8'h5A, 1'b1);
    t = 0;
    while (!(rx_exp.size() == 0 && tx_exp.size() == 0 && idle_a) && t < 800) begin
      @(negedge clk);
      t++;
    end
    check("loop_done", {31'h0, (rx_exp.size() == 0 && tx_exp.size() == 0 && idle_a)}, 1);
    repeat (3) @(negedge clk);
    check("loop_parity_err", {31'h0, perr_a}, 0);
    check("loop_frame_err", {31'h0, ferr_a}, 0);
    check("loop_valid_empty", {31'h0, valid_a}, 0);
    loop_en = 1'b0;

    // TX burst into a 4-deep FIFO
    for (int i = 0; i < 6; i++) begin
      txd_a = 8'h11 + 8'(i);
      wr_a  = 1'b1;
      if (i < 5) tx_exp.push_back(txd_a);
      @(negedge clk);
      if (i == 3) check("burst_busy_after4", {31'h0, busy_a}, 0);
      if (i == 4) check("burst_busy_after5", {31'h0, busy_a}, 1);
      if (i == 5) check("burst_busy_after6", {31'h0, busy_a}, 1);
    end
    wr_a = 1'b0;
    check("burst_tx_idle_low", {31'h0, idle_a}, 0);
    t = 0;
    while (!(tx_exp.size() == 0 && idle_a) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("burst_done", {31'h0, (tx_exp.size() == 0 && idle_a)}, 1);
    repeat (2*DIV*11) @(negedge clk);
    check("burst_no_extra", {31'h0, idle_a}, 1);

    // RX overrun: five frames, no reads
    rd_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) rx_exp.push_back(8'h31 + 8'(i));
      send_frame(8'h31 + 8'(i), 1'b0, 1'b0);
    end
    check("ovr_valid", {31'h0, valid_a}, 1);
    check("ovr_flag", {31'h0, ovr_a}, 1);
    check("ovr_no_perr", {31'h0, perr_a}, 0);
    check("ovr_no_ferr", {31'h0, ferr_a}, 0);
    rd_en = 1'b1;
    t = 0;
    while (rx_exp.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("ovr_drain", 32'(rx_exp.size()), 0);
    repeat (3) @(negedge clk);
    check("ovr_valid_after_drain", {31'h0, valid_a}, 0);
    check("ovr_sticky", {31'h0, ovr_a}, 1);
    pulse_clr();
    check("ovr_cleared", {31'h0, ovr_a}, 0);

    // Parity error: flag set, word still delivered
    rx_exp.push_back(8'h6C);
    send_frame(8'h6C, 1'b1, 1'b0);
    check("perr_flag", {31'h0, perr_a}, 1);
    check("perr_no_ferr", {31'h0, ferr_a}, 0);
    check("perr_word_delivered", 32'(rx_exp.size()), 0);
    pulse_clr();
    check("perr_cleared", {31'h0, perr_a}, 0);

    // Framing error: no push
    rd_en = 1'b0;
    send_frame(8'h99, 1'b0, 1'b1);
    check("ferr_flag", {31'h0, ferr_a}, 1);
    check("ferr_no_push", {31'h0, valid_a}, 0);
    pulse_clr();
    check("ferr_cleared", {31'h0, ferr_a}, 0);

    // 3-cycle glitch is a false start
    rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    repeat (4*DIV) @(negedge clk);
    check("glitch_no_push", {31'h0, valid_a}, 0);
    check("glitch_no_flags", {29'h0, perr_a, ferr_a, ovr_a}, 0);

    // Reset in the middle of a frame
    rd_en = 1'b1;
    write_a(8'h00, 1'b0);
    write_a(8'h00, 1'b0);
    write_a(8'h00, 1'b0);
    repeat (30) @(negedge clk);
    check("pre_reset_tx_low", {31'h0, tx_a}, 0);
    check("pre_reset_busy_frame", {31'h0, idle_a}, 0);
    #2;
    reset_i = 1'b0;
    epoch++;
    tx_exp.delete();
    #1;
    check("reset_tx_high_now", {31'h0, tx_a}, 1);
    check("reset_tx_idle", {31'h0, idle_a}, 1);
    @(negedge clk);
    reset_i = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_fifo_empty", {31'h0, idle_a}, 1);
    repeat (200) @(negedge clk);
    check("post_reset_line_idle", {31'h0, tx_a}, 1);

    // Transmission after reset
    write_a(8'hC3, 1'b0);
    t = 0;
    while (!(tx_exp.size() == 0 && idle_a) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("post_reset_frame", {31'h0, (tx_exp.size() == 0 && idle_a)}, 1);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_buffered.md
UART_BUFFERED -- requirements
Module: uart_buffered

Interface
REQ-001 Parameter FREQ_HZ SHALL default to 12000000 and give the clk frequency in Hz.
REQ-002 Parameter BAUDS SHALL default to 115200 and give the line bit rate.
REQ-003 Parameter DATA_BITS SHALL default to 8 and give data bits per frame, legal range 5..8.
REQ-004 Parameter PARITY SHALL default to 0 and select parity: 0 none, 1 odd, 2 even.
REQ-005 Parameter STOP_BITS SHALL default to 1 and give stop bits per frame, legal values 1 and 2.
REQ-006 Parameter FIFO_DEPTH SHALL default to 16 and give the entries per FIFO, a power of 2 that is at least 2.
REQ-007 The ports SHALL be, in order (name, direction, width, meaning):
- clk, in, 1, the single clock;
- reset_i, in, 1, asynchronous active-low reset;
- tx_o, out, 1, serial output;
- rx_i, in, 1, asynchronous serial input;
- wr_i, in, 1, push tx_data_i into the TX FIFO;
- tx_data_i, in, DATA_BITS, TX word;
- rd_i, in, 1, pop the RX FIFO head;
- rx_data_o, out, DATA_BITS, RX FIFO head;
- busy_o, out, 1, TX FIFO full;
- valid_o, out, 1, RX FIFO non-empty;
- tx_idle_o, out, 1, TX FIFO empty and transmitter idle;
- parity_err_o, out, 1, sticky parity error;
- frame_err_o, out, 1, sticky framing error;
- overrun_o, out, 1, sticky RX overrun;
- clr_err_i, in, 1, clear all sticky errors.

Function
REQ-008 The bit period SHALL be DIV = (FREQ_HZ + BAUDS/2) / BAUDS clk cycles (integer, rounded), and DIV < 4 SHALL be a fatal elaboration error.
REQ-009 Each frame SHALL be: start (0), DATA_BITS data LSB first, one parity bit if PARITY != 0, then STOP_BITS stop bits (1).
REQ-010 The parity bit SHALL make the total number of 1s in data plus parity odd (PARITY=1) or even (PARITY=2).
REQ-011 In each FIFO, wr_i SHALL push only when the FIFO is not full; a push while full is dropped, with no state change.
REQ-012 rd_i SHALL pop only when valid_o=1; rd_i while empty is ignored.
REQ-013 rx_data_o SHALL be first-word-fall-through: it shows the head the cycle after the word is written, and is undefined when valid_o=0.
REQ-014 Simultaneous push and pop on the same FIFO SHALL both take effect; if the FIFO is full, the pop frees space in the same cycle and the push is accepted.
REQ-015 Pointers SHALL be log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH; full and empty are decoded from the MSB and the equal low bits.
REQ-016 TX FSM states SHALL be IDLE, START, DATA, PARITY, STOP, with each non-IDLE state holding its line level for exactly DIV cycles.
REQ-017 TX in IDLE with the FIFO non-empty SHALL pop the head and enter START on the next cycle (tx_o=0); DATA lasts DATA_BITS periods; PARITY is skipped when PARITY=0; STOP lasts STOP_BITS periods; then the FSM returns to IDLE, or goes straight to START if the FIFO is non-empty (no idle gap).
REQ-018 tx_o SHALL be 1 in IDLE.
REQ-019 rx_i SHALL pass through a 2-flop synchronizer before any use.
REQ-020 RX FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-021 A synchronized 1->0 transition in RX IDLE SHALL enter START; the line is sampled DIV/2 cycles later, and a sample of 1 is a false start that returns to IDLE with no flag set.
REQ-022 Subsequent RX samples SHALL be taken every DIV cycles, at mid-bit.
REQ-023 Only the first stop bit SHALL be checked on RX; a sample of 0 sets frame_err_o, discards the word, and the FSM waits in IDLE for the line to return to 1 before re-arming.
REQ-024 A parity mismatch SHALL set parity_err_o and still push the word.
REQ-025 A valid word arriving while the RX FIFO is full SHALL set overrun_o and be dropped; FIFO contents are unchanged.
REQ-026 The error flags SHALL be sticky until clr_err_i; a set event in the same cycle as clr_err_i wins, and the flag stays 1.
REQ-027 tx_idle_o SHALL be 1 only when the TX FIFO is empty and the TX FSM is in IDLE.

Reset
REQ-028 reset_i=0 SHALL asynchronously clear FIFO pointers, FSMs (to IDLE), counters and error flags, and preload the synchronizer with 1.
REQ-029 Output values during reset SHALL be: tx_o=1, busy_o=0, valid_o=0, tx_idle_o=1, and all error flags 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately (tx_o=1); the partial word is lost and FIFO contents are discarded.
REQ-031 Deassertion SHALL be usable synchronously to clk, with the first frame possible on the cycle after release.

Verification
REQ-032 Scenario: FREQ_HZ=12e6, BAUDS=1e6 (DIV=12), 8N1; wr_i 0xA5 -> tx_o is 0,1,0,1,0,0,1,0,1,1, each level held 12 cycles.
REQ-033 Scenario: tx_o looped to rx_i, PARITY=2, words 0x00, 0xFF, 0x5A -> rx_data_o returns them in order, parity_err_o=0.
REQ-034 Scenario: FIFO_DEPTH=4, 5 writes in one burst with TX stalled behind the first word -> busy_o=1 after the 5th (1 word in the shifter plus 4 queued); a 6th write is dropped; the line carries exactly 5 words.
REQ-035 Scenario: 5 frames received with rd_i=0 and FIFO_DEPTH=4 -> valid_o=1, overrun_o=1, and reads return words 1-4.
REQ-036 Scenario: frame with stop bit forced to 0 -> frame_err_o=1 and no push; then clr_err_i pulse -> frame_err_o=0.
REQ-037 Scenario: 0-pulse on rx_i of 3 cycles (DIV=12) -> no push, no flags; reset_i=0 mid-TX-frame -> tx_o=1 within the same cycle.
